// File: rtl/redmule_tcdm_arbiter.sv
// Shares RedMulE's single TCDM port between the load streams and the Z store.
// Round-robin load arbitration, optional store priority, lock-until-grant, in-order response routing.
module redmule_tcdm_arbiter #(
  parameter int N_SRC     = 5,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 544,
  parameter int MAX_OUTST = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          z_priority_i,
  input  logic [N_SRC-1:0]              ld_req_i,
  input  logic [N_SRC*ADDR_W-1:0]       ld_add_i,
  output logic [N_SRC-1:0]              ld_gnt_o,
  output logic [N_SRC-1:0]              ld_r_valid_o,
  output logic [DATA_W-1:0]             ld_r_data_o,
  input  logic                          st_req_i,
  input  logic [ADDR_W-1:0]             st_add_i,
  input  logic [DATA_W-1:0]             st_data_i,
  input  logic [DATA_W/8-1:0]           st_be_i,
  output logic                          st_gnt_o,
  output logic                          mem_req_o,
  output logic                          mem_wen_o,
  output logic [ADDR_W-1:0]             mem_add_o,
  output logic [DATA_W-1:0]             mem_data_o,
  output logic [DATA_W/8-1:0]           mem_be_o,
  input  logic                          mem_gnt_i,
  input  logic                          mem_r_valid_i,
  input  logic [DATA_W-1:0]             mem_r_data_i,
  output logic [$clog2(MAX_OUTST):0]    outst_o,
  output logic                          resp_err_o
);

  localparam int SLOT_W = $clog2(N_SRC + 1);
  localparam int PTR_W  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W  = $clog2(MAX_OUTST) + 1;
  localparam int ID_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [SLOT_W-1:0] ST_SLOT = SLOT_W'(N_SRC);

  logic [SLOT_W-1:0] rr_ptr, lock_idx_q, sel_idx;
  logic              lock_q, sel_valid;
  logic [ID_W-1:0]   id_fifo [MAX_OUTST];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              resp_err_q;
  logic              fifo_full, push, pop, sel_store;
  logic [N_SRC:0]    elig;

  assign fifo_full = (count == CNT_W'(MAX_OUTST));
  assign elig      = {st_req_i, ld_req_i & {N_SRC{~fifo_full}}};

  // A locked requester keeps the port regardless of priority or other requests.
  always_comb begin
    int j;
    j         = 0;
    sel_valid = 1'b0;
    sel_idx   = '0;
    if (lock_q) begin
      sel_valid = 1'b1;
      sel_idx   = lock_idx_q;
    end else if (z_priority_i && st_req_i) begin
      sel_valid = 1'b1;
      sel_idx   = ST_SLOT;
    end else begin
      for (int k = 0; k <= N_SRC; k++) begin
        j = int'(rr_ptr) + k;
        if (j > N_SRC) j = j - (N_SRC + 1);
        if (!sel_valid && elig[j]) begin
          sel_valid = 1'b1;
          sel_idx   = SLOT_W'(j);
        end
      end
    end
  end

  assign sel_store = sel_valid && (sel_idx == ST_SLOT);
  assign mem_req_o = sel_valid;
  assign st_gnt_o  = mem_gnt_i && sel_store;
  assign push      = mem_gnt_i && sel_valid && !sel_store;
  assign pop       = mem_r_valid_i && (count != '0);

  always_comb begin
    mem_wen_o  = 1'b1;
    mem_add_o  = '0;
    mem_data_o = '0;
    mem_be_o   = '1;
    if (sel_store) begin
      mem_wen_o  = 1'b0;
      mem_add_o  = st_add_i;
      mem_data_o = st_data_i;
      mem_be_o   = st_be_i;
    end else begin
      for (int i = 0; i < N_SRC; i++)
        if (sel_valid && sel_idx == SLOT_W'(i)) mem_add_o = ld_add_i[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      ld_gnt_o[i]     = mem_gnt_i && sel_valid && (sel_idx == SLOT_W'(i));
      ld_r_valid_o[i] = pop && (id_fifo[rd_ptr] == ID_W'(i));
    end
  end

  assign ld_r_data_o = mem_r_data_i;
  assign outst_o     = count;
  assign resp_err_o  = resp_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr     <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      resp_err_q <= 1'b0;
      for (int i = 0; i < MAX_OUTST; i++) id_fifo[i] <= '0;
    end else begin
      if (sel_valid && !mem_gnt_i) begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel_idx;
      end
      if (sel_valid && mem_gnt_i) begin
        lock_q <= 1'b0;
        rr_ptr <= sel_store ? '0 : sel_idx + 1'b1;
      end
      if (push) begin
        id_fifo[wr_ptr] <= ID_W'(sel_idx);
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      // Responses with nothing outstanding are dropped but remembered.
      if (mem_r_valid_i && count == '0) resp_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_redmule_tcdm_arbiter.sv
// Directed bench for redmule_tcdm_arbiter: round-robin, store priority, lock, FIFO full,
// simultaneous push/pop and orphan-response error.
module tb_redmule_tcdm_arbiter;
  localparam int N_SRC = 5, ADDR_W = 32, DATA_W = 544, MAX_OUTST = 4;

  logic                       clk = 1'b0, rst;
  logic                       z_priority;
  logic [N_SRC-1:0]           ld_req, ld_gnt, ld_r_valid;
  logic [N_SRC*ADDR_W-1:0]    ld_add;
  logic [DATA_W-1:0]          ld_r_data, st_data, mem_data, mem_r_data;
  logic                       st_req, st_gnt, mem_req, mem_wen, mem_gnt, mem_r_valid, resp_err;
  logic [ADDR_W-1:0]          st_add, mem_add;
  logic [DATA_W/8-1:0]        st_be, mem_be;
  logic [$clog2(MAX_OUTST):0] outst;

  int checks = 0;
  int errors = 0;

  redmule_tcdm_arbiter #(.N_SRC(N_SRC), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)) dut (
    .clk_i(clk), .rst_i(rst), .z_priority_i(z_priority),
    .ld_req_i(ld_req), .ld_add_i(ld_add), .ld_gnt_o(ld_gnt),
    .ld_r_valid_o(ld_r_valid), .ld_r_data_o(ld_r_data),
    .st_req_i(st_req), .st_add_i(st_add), .st_data_i(st_data), .st_be_i(st_be), .st_gnt_o(st_gnt),
    .mem_req_o(mem_req), .mem_wen_o(mem_wen), .mem_add_o(mem_add), .mem_data_o(mem_data),
    .mem_be_o(mem_be), .mem_gnt_i(mem_gnt), .mem_r_valid_i(mem_r_valid), .mem_r_data_i(mem_r_data),
    .outst_o(outst), .resp_err_o(resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ld_addr(input int i);
    return 32'h1000 + 32'(i) * 32'h40;
  endfunction

  int seq [6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    rst = 1'b1; z_priority = 1'b0; ld_req = '0; st_req = 1'b0; mem_gnt = 1'b0;
    mem_r_valid = 1'b0; mem_r_data = '0; st_add = 32'h8000_0000;
    st_data = '0; st_data[31:0] = 32'hDEAD_BEEF;
    st_be = '0; st_be[7:0] = 8'hA5;
    for (int i = 0; i < N_SRC; i++) ld_add[i*ADDR_W +: ADDR_W] = ld_addr(i);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ld_gnt", ld_gnt, 0);
    chk("rst_st_gnt", st_gnt, 0);
    chk("rst_r_valid", ld_r_valid, 0);
    chk("rst_outst", outst, 0);
    chk("rst_err", resp_err, 0);
    tick();

    // Round-robin among loads 0,1,3 with one-cycle responses.
    ld_req = 5'b01011; mem_gnt = 1'b1;
    for (int k = 0; k < 6; k++) begin
      mem_r_valid = (k > 0);
      mem_r_data[31:0] = 32'h100 + 32'(k);
      #1;
      chk("rr_gnt", ld_gnt, 64'(1) << seq[k]);
      chk("rr_add", mem_add, ld_addr(seq[k]));
      chk("rr_wen", mem_wen, 1);
      chk("rr_rvalid", ld_r_valid, (k > 0) ? (64'(1) << seq[k > 0 ? k - 1 : 0]) : 64'(0));
      tick();
    end
    ld_req = '0; mem_r_valid = 1'b1; mem_r_data[31:0] = 32'h1234_5678;
    #1;
    chk("rr_last_rvalid", ld_r_valid, 5'b01000);
    chk("rr_rdata", ld_r_data[31:0], 32'h1234_5678);
    chk("rr_idle_req", mem_req, 0);
    tick();
    mem_r_valid = 1'b0;
    #1;
    chk("rr_outst_drained", outst, 0);

    // Store priority: store wins every cycle, loads resume at slot 0.
    ld_req = 5'b11111; st_req = 1'b1; z_priority = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("zp_st_gnt", st_gnt, 1);
      chk("zp_ld_gnt", ld_gnt, 0);
      chk("zp_wen", mem_wen, 0);
      chk("zp_add", mem_add, 32'h8000_0000);
      chk("zp_data", mem_data[63:0], 64'hDEAD_BEEF);
      chk("zp_be", mem_be[63:0], 64'hA5);
      tick();
    end
    st_req = 1'b0;
    #1;
    chk("zp_resume0", ld_gnt, 5'b00001);
    chk("zp_rd_data0", mem_data[63:0], 0);
    chk("zp_rd_be", &mem_be, 1);
    tick();
    #1;
    chk("zp_resume1", ld_gnt, 5'b00010);
    tick();
    #1;
    chk("zp_outst2", outst, 2);

    // Push and pop together at count 2: response goes to oldest ID (0).
    ld_req = 5'b00100; mem_r_valid = 1'b1;
    #1;
    chk("pp_gnt", ld_gnt, 5'b00100);
    chk("pp_rvalid", ld_r_valid, 5'b00001);
    tick();
    ld_req = '0;
    #1;
    chk("pp_outst", outst, 2);
    chk("pp_rvalid2", ld_r_valid, 5'b00010);
    tick();
    #1;
    chk("pp_rvalid3", ld_r_valid, 5'b00100);
    tick();
    mem_r_valid = 1'b0;
    #1;
    chk("pp_outst0", outst, 0);

    // Lock: load 2 held without grant while store rises with priority.
    ld_req = 5'b00100; mem_gnt = 1'b0; z_priority = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin st_req = 1'b1; z_priority = 1'b1; end
      #1;
      chk("lk_req", mem_req, 1);
      chk("lk_add", mem_add, ld_addr(2));
      chk("lk_no_gnt", {st_gnt, ld_gnt}, 0);
      tick();
    end
    mem_gnt = 1'b1;
    #1;
    chk("lk_ld2_gnt", ld_gnt, 5'b00100);
    chk("lk_ld2_st", st_gnt, 0);
    chk("lk_ld2_add", mem_add, ld_addr(2));
    tick();
    ld_req = '0;
    #1;
    chk("lk_st_gnt", st_gnt, 1);
    chk("lk_st_wen", mem_wen, 0);
    tick();
    st_req = 1'b0; z_priority = 1'b0; mem_r_valid = 1'b1;
    #1;
    chk("lk_rvalid", ld_r_valid, 5'b00100);
    tick();
    mem_r_valid = 1'b0;
    #1;
    chk("lk_outst0", outst, 0);

    // FIFO full: four reads outstanding block loads but not the store.
    ld_req = 5'b00001;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("full_fill_gnt", ld_gnt, 5'b00001);
      tick();
    end
    #1;
    chk("full_outst4", outst, 4);
    chk("full_blocked", ld_gnt, 0);
    chk("full_no_req", mem_req, 0);
    st_req = 1'b1;
    #1;
    chk("full_st_gnt", st_gnt, 1);
    tick();
    st_req = 1'b0; mem_r_valid = 1'b1;
    #1;
    chk("full_still_blocked", ld_gnt, 0);
    chk("full_rvalid", ld_r_valid, 5'b00001);
    tick();
    mem_r_valid = 1'b0;
    #1;
    chk("full_outst3", outst, 3);
    chk("full_ld_resume", ld_gnt, 5'b00001);
    tick();
    ld_req = '0;
    #1;
    chk("full_outst4b", outst, 4);
    mem_r_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("full_drain", ld_r_valid, 5'b00001);
      tick();
    end
    mem_r_valid = 1'b0;
    #1;
    chk("full_outst0", outst, 0);

    // Orphan response sets sticky error; reset clears it and rr_ptr.
    mem_r_valid = 1'b1;
    #1;
    chk("err_no_rvalid", ld_r_valid, 0);
    tick();
    mem_r_valid = 1'b0;
    #1;
    chk("err_set", resp_err, 1);
    chk("err_outst", outst, 0);
    tick();
    #1;
    chk("err_sticky", resp_err, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("err_cleared", resp_err, 0);
    chk("err_rst_outst", outst, 0);
    ld_req = 5'b10001;
    #1;
    chk("rst_rr_ptr0", ld_gnt, 5'b00001);
    tick();
    ld_req = '0; mem_gnt = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
